// File: rtl/usrp2puf_capture.sv
// usrp2puf_capture: power-triggered I/Q burst capture.
// Keeps a ring of recent samples; when I^2+Q^2 exceeds the threshold
// (or unconditionally in free-run mode) it records one WINDOW-sample frame
// with PRETRIG samples of history, then streams it out with tlast.
module usrp2puf_capture #(
    parameter int DATA_WIDTH = 16,
    parameter int WINDOW     = 256,
    parameter int PRETRIG    = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [2*DATA_WIDTH-1:0] in_tdata,
    input  logic                    in_tvalid,
    input  logic                    in_tlast,
    output logic                    in_tready,
    input  logic [2*DATA_WIDTH-1:0] threshold,
    input  logic                    mode,
    output logic [2*DATA_WIDTH-1:0] out_tdata,
    output logic                    out_tvalid,
    output logic                    out_tlast,
    input  logic                    out_tready,
    output logic                    busy,
    output logic [15:0]             frame_count
);

    localparam int DW2 = 2 * DATA_WIDTH;
    localparam int AW  = $clog2(WINDOW);
    localparam int HW  = $clog2(PRETRIG + 1);

    localparam logic [HW-1:0] PRE_LAST  = HW'(PRETRIG - 1);
    localparam logic [AW-1:0] CAP_LAST  = AW'(WINDOW - PRETRIG - 1);
    localparam logic [AW-1:0] PRE_OFS   = AW'(PRETRIG);
    localparam logic [AW:0]   BEATS     = (AW + 1)'(WINDOW);
    localparam logic [AW:0]   BEAT_LAST = (AW + 1)'(WINDOW - 1);

    typedef enum logic [1:0] {FILL, ARMED, CAPTURE, DRAIN} state_t;

    state_t          state;
    logic [AW-1:0]   wptr;
    logic [HW-1:0]   hcount;
    logic [AW-1:0]   post_cnt;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     issued;
    logic [DW2-1:0]  ring [WINDOW];

    logic                         accept;
    logic                         rd_en;
    logic                         fire;
    logic signed [DATA_WIDTH-1:0] s_i;
    logic signed [DATA_WIDTH-1:0] s_q;
    logic signed [DW2-1:0]        ii;
    logic signed [DW2-1:0]        qq;
    logic [DW2-1:0]               power;
    logic                         unused_in_tlast;

    assign unused_in_tlast = in_tlast;

    assign accept = in_tvalid & in_tready;
    assign s_i    = in_tdata[DW2-1:DATA_WIDTH];
    assign s_q    = in_tdata[DATA_WIDTH-1:0];
    // Each square is at most 2^(2DW-2), so the sum fits unsigned in 2*DW bits
    assign ii     = DW2'(s_i) * DW2'(s_i);
    assign qq     = DW2'(s_q) * DW2'(s_q);
    assign power  = ii + qq;
    assign fire   = mode | (power > threshold);

    // The output register doubles as the RAM read register: a new word is
    // fetched only when the held beat is empty or being taken this cycle.
    assign rd_en  = (state == DRAIN) && (!out_tvalid || out_tready) && (issued != BEATS);

    // Ring buffer write port
    always_ff @(posedge clk) begin
        if (accept) begin
            ring[wptr] <= in_tdata;
        end
    end

    // Capture/drain state machine with registered stream outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= FILL;
            wptr        <= '0;
            hcount      <= '0;
            post_cnt    <= '0;
            rd_ptr      <= '0;
            issued      <= '0;
            in_tready   <= 1'b0;
            out_tdata   <= '0;
            out_tvalid  <= 1'b0;
            out_tlast   <= 1'b0;
            busy        <= 1'b0;
            frame_count <= '0;
        end else begin
            case (state)
                FILL: begin
                    in_tready <= 1'b1;
                    if (accept) begin
                        wptr   <= wptr + 1'b1;
                        hcount <= hcount + 1'b1;
                        if (hcount == PRE_LAST) begin
                            state <= ARMED;
                        end
                    end
                end
                ARMED: begin
                    if (accept) begin
                        wptr <= wptr + 1'b1;
                        if (fire) begin
                            rd_ptr   <= wptr - PRE_OFS;
                            post_cnt <= AW'(1);
                            busy     <= 1'b1;
                            if (CAP_LAST == '0) begin
                                state     <= DRAIN;
                                in_tready <= 1'b0;
                                issued    <= '0;
                            end else begin
                                state <= CAPTURE;
                            end
                        end
                    end
                end
                CAPTURE: begin
                    if (accept) begin
                        wptr     <= wptr + 1'b1;
                        post_cnt <= post_cnt + 1'b1;
                        if (post_cnt == CAP_LAST) begin
                            state     <= DRAIN;
                            in_tready <= 1'b0;
                            issued    <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (rd_en) begin
                        out_tdata  <= ring[rd_ptr];
                        out_tvalid <= 1'b1;
                        out_tlast  <= (issued == BEAT_LAST);
                        rd_ptr     <= rd_ptr + 1'b1;
                        issued     <= issued + 1'b1;
                    end else if (out_tvalid && out_tready) begin
                        out_tvalid <= 1'b0;
                        out_tlast  <= 1'b0;
                        if (out_tlast) begin
                            state       <= FILL;
                            hcount      <= '0;
                            in_tready   <= 1'b1;
                            busy        <= 1'b0;
                            frame_count <= frame_count + 16'd1;
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_usrp2puf_capture.sv
// tb_usrp2puf_capture: directed checks of capture framing, thresholding,
// output back-pressure and mid-drain reset.
module tb_usrp2puf_capture;

    localparam int DW  = 16;
    localparam int WIN = 256;
    localparam int PRE = 32;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [2*DW-1:0] in_tdata;
    logic            in_tvalid;
    logic            in_tlast;
    logic            in_tready;
    logic [2*DW-1:0] threshold;
    logic            mode;
    logic [2*DW-1:0] out_tdata;
    logic            out_tvalid;
    logic            out_tlast;
    logic            out_tready;
    logic            busy;
    logic [15:0]     frame_count;

    int n_vec = 0;
    int n_bad = 0;

    usrp2puf_capture #(
        .DATA_WIDTH (DW),
        .WINDOW     (WIN),
        .PRETRIG    (PRE)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_tdata    (in_tdata),
        .in_tvalid   (in_tvalid),
        .in_tlast    (in_tlast),
        .in_tready   (in_tready),
        .threshold   (threshold),
        .mode        (mode),
        .out_tdata   (out_tdata),
        .out_tvalid  (out_tvalid),
        .out_tlast   (out_tlast),
        .out_tready  (out_tready),
        .busy        (busy),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sample n of stimulus pattern tc, packed {I, Q}.
    // tc 0: ramp I=n, Q=-n. Others: low-power background (p <= 450) plus spikes.
    function automatic logic [2*DW-1:0] gen(input int tc, input int n);
        logic [DW-1:0] i;
        logic [DW-1:0] q;
        if (tc == 0) begin
            i = 16'(n);
            q = 16'(-n);
        end else begin
            i = {12'd0, 4'(n)};
            q = {12'd0, 4'(n >> 4)};
            if (tc == 1 && n == 100) begin
                i = 16'd40; q = 16'd0;
            end
            if (tc == 2 && (n == 10 || n == 200)) begin
                i = 16'd40; q = 16'd0;
            end
            if (tc == 3 && n == 100) begin
                i = 16'd30; q = 16'd10;
            end
        end
        return {i, q};
    endfunction

    task automatic do_reset();
        in_tvalid  = 1'b0;
        in_tdata   = '0;
        out_tready = 1'b1;
        reset_n    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state",
              64'({in_tready, out_tvalid, out_tlast, busy, frame_count, out_tdata}), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", 64'(in_tready), 64'd1);
    endtask

    // Streams pattern tc continuously; checks every valid output cycle
    // against the expected frame sample. rst_beat >= 0 asserts reset at that
    // beat of the second frame and checks that outputs clear at once.
    task automatic run_case(input int tc, input logic md, input logic [2*DW-1:0] thr,
                            input int nfr, input int st0, input int st1,
                            input bit stall, input int rst_beat, input int budget);
        int   n;
        int   beat;
        int   frames;
        int   valid_seen;
        bit   stop;
        bit   aborted;
        logic acc_in;
        logic [2*DW-1:0] exp;
        mode       = md;
        threshold  = thr;
        n          = 0;
        beat       = 0;
        frames     = 0;
        valid_seen = 0;
        stop       = 1'b0;
        aborted    = 1'b0;
        in_tdata   = gen(tc, 0);
        in_tvalid  = 1'b1;
        for (int cyc = 0; cyc < budget && !stop; cyc++) begin
            out_tready = stall ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
            @(negedge clk);
            acc_in = in_tvalid && in_tready;
            if (out_tvalid) begin
                valid_seen++;
                exp = gen(tc, ((frames == 0) ? st0 : st1) + beat);
                check("beat", 64'({busy, in_tready, out_tlast, out_tdata}),
                      64'({1'b1, 1'b0, beat == WIN - 1, exp}));
                if (rst_beat >= 0 && frames == 1 && beat == rst_beat) begin
                    reset_n = 1'b0;
                    #1;
                    check("reset_in_drain",
                          64'({in_tready, out_tvalid, out_tlast, busy, frame_count, out_tdata}),
                          64'd0);
                    stop    = 1'b1;
                    aborted = 1'b1;
                end else if (out_tready) begin
                    beat++;
                    if (beat == WIN) begin
                        frames++;
                        beat = 0;
                        if (frames == nfr) stop = 1'b1;
                    end
                end
            end
            if (!aborted) begin
                @(posedge clk);
                #1;
                if (acc_in) n++;
                in_tdata = gen(tc, n);
            end
        end
        in_tvalid = 1'b0;
        if (aborted) begin
            check("frames_before_reset", 64'(frames), 64'd1);
        end else begin
            check("frames_seen", 64'(frames), 64'(nfr));
            check("frame_count", 64'(frame_count), 64'(nfr));
            if (nfr == 0) check("no_valid", 64'(valid_seen), 64'd0);
        end
    endtask

    initial begin
        in_tlast  = 1'b0;
        threshold = '0;
        mode      = 1'b0;

        // Free-run ramp: two back-to-back frames 0..255, 256..511
        do_reset();
        run_case(0, 1'b1, 32'd0, 2, 0, 256, 1'b0, -1, 1500);

        // Single spike at sample 100 -> frame 68..323
        do_reset();
        run_case(1, 1'b0, 32'd1000, 1, 68, 0, 1'b0, -1, 1200);

        // Spike during FILL is ignored; spike at 200 -> frame 168..423
        do_reset();
        run_case(2, 1'b0, 32'd1000, 1, 168, 0, 1'b0, -1, 1200);

        // Power exactly equal to threshold never triggers
        do_reset();
        run_case(3, 1'b0, 32'd1000, 0, 0, 0, 1'b0, -1, 600);

        // Spike case under periodic downstream stalls
        do_reset();
        run_case(1, 1'b0, 32'd1000, 1, 68, 0, 1'b1, -1, 1500);

        // Reset at beat 100 of second free-run drain, then a fresh trigger
        do_reset();
        run_case(0, 1'b1, 32'd0, 2, 0, 256, 1'b0, 100, 1500);
        do_reset();
        run_case(1, 1'b0, 32'd1000, 1, 68, 0, 1'b0, -1, 1200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/usrp2puf_capture.md
Name: usrp2puf_capture

Overview:
Parametrised successor to the usrp2puf stream stage. It watches an AXI-stream of packed I/Q samples and detects a burst by instantaneous power (I²+Q²) crossing a runtime threshold. On detection it emits exactly one fixed-length frame containing pre-trigger history plus post-trigger samples, with tlast on the final beat. It sits between the radio sample stream and the PUF feature-extraction path, and also supports a free-run mode for back-to-back windows.

Parameters:
DATA_WIDTH, 16, width of each I and Q component (signed two's complement)
WINDOW, 256, samples per output frame; power of 2, ≥4
PRETRIG, 32, samples kept before the trigger sample; 1 ≤ PRETRIG < WINDOW

Ports:
clk  in  1  sample clock
reset_n  in  1  asynchronous, active-low reset
in_tdata  in  2*DATA_WIDTH  {I[2*DW-1:DW], Q[DW-1:0]}
in_tvalid  in  1  input beat valid
in_tlast  in  1  ignored
in_tready  out  1  input accept
threshold  in  2*DATA_WIDTH  unsigned power threshold
mode  in  1  0 = triggered, 1 = free-run
out_tdata  out  2*DATA_WIDTH  frame sample, same packing as input
out_tvalid  out  1  output beat valid
out_tlast  out  1  last beat of frame
out_tready  in  1  downstream accept
busy  out  1  high in CAPTURE or DRAIN
frame_count  out  16  completed frames, wraps at 2^16

Behaviour:
- Reset (reset_n=0, asynchronous): state=FILL, write pointer=0, history count=0, in_tready=0, out_tvalid=0, out_tlast=0, out_tdata=0, busy=0, frame_count=0. After release, in_tready=1 from the first clock edge. Any partial frame is discarded.
- Accept = in_tvalid & in_tready. Each accepted sample is written to a ring RAM of depth WINDOW at wptr; wptr increments mod WINDOW.
- Power: p = I*I + Q*Q, computed on the accepted beat, unsigned 2*DATA_WIDTH (max 2^(2DW-1), no overflow). Trigger condition is strict: p > threshold.
- FILL: accept samples; hcount increments. Triggers are ignored. When hcount reaches PRETRIG, go to ARMED.
- ARMED: on an accepted sample, fire if (mode=0 and p>threshold) or mode=1. The firing sample becomes frame index PRETRIG. Latch rd_start = (its write address − PRETRIG) mod WINDOW. Go to CAPTURE with post-count = 1 (firing sample included). mode and threshold are only sampled here.
- CAPTURE: accept samples, ignore further triggers. When post-count reaches WINDOW−PRETRIG, go to DRAIN. The ring then holds exactly WINDOW samples; no overwrite of history occurs.
- DRAIN: in_tready=0. Read WINDOW samples from rd_start upward mod WINDOW, using a synchronous-read RAM plus output register/skid.
  - First out_tvalid appears no later than 2 cycles after entering DRAIN.
  - Full throughput when out_tready=1.
  - While out_tvalid=1 and out_tready=0, out_tdata and out_tlast hold stable; no beat is dropped or duplicated.
  - out_tlast=1 only on beat WINDOW−1.
- On the accepted last beat: frame_count++, hcount=0, state=FILL, in_tready=1 the next cycle.
- busy is registered and tracks state.

Test Plan:
- Free-run (mode=1), WINDOW=256, PRETRIG=32, ramp input I=n, Q=−n, out_tready=1 -> frame0 beats carry n=0..255; frame1 carries n=256..511; tlast on beats 255/511; frame_count=2.
- Triggered, threshold=1000, zeros except sample 100 with I=40, Q=0 (p=1600) -> one frame of samples 68..323; beat 32 = (40,0); tlast beat 255; frame_count=1.
- Spike at sample 10 (during FILL) and sample 200 -> sample 10 ignored; frame starts at sample 168.
- Spike with p exactly equal to threshold (I=30, Q=10, threshold=1000) -> no frame; out_tvalid stays 0; frame_count=0.
- Case 2 with out_tready toggling 1,0,0,1 periodically -> 256 beats in order, no duplicates; data and tlast stable while stalled; in_tready=0 until final accept.
- Assert reset_n=0 at beat 100 of DRAIN -> outputs clear immediately; after release, FILL with frame_count=0; a new trigger yields a full correct frame.
